// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit beside ID: per-register countdown scoreboard with
// configurable load latency, XZR exclusion, branch-flush handling and a stall counter.
module hazard_scoreboard #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rn,
    input  logic [REG_W-1:0]    id_rm,
    input  logic                id_use_rn,
    input  logic                id_use_rm,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_is_load,
    input  logic                ex_branch_taken,
    output logic                stall,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                idex_bubble,
    output logic                ifid_flush,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CNT_W-1:0]    stall_count
);

    localparam int unsigned CTR_W = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);

    logic [CTR_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] stall_count_q;
    logic             hz_rn;
    logic             hz_rm;
    logic             issue;

    // Only the prior counter state is consulted, so a load never stalls on its own rd.
    assign hz_rn = id_use_rn && (id_rn != REG_W'(ZERO_REG)) && (cnt_q[id_rn] != '0);
    assign hz_rm = id_use_rm && (id_rm != REG_W'(ZERO_REG)) && (cnt_q[id_rm] != '0);

    assign stall       = id_valid && (hz_rn || hz_rm) && !ex_branch_taken;
    assign issue       = id_valid && !stall && !ex_branch_taken;
    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall || ex_branch_taken;
    assign ifid_flush  = ex_branch_taken;
    assign stall_count = stall_count_q;

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pending_mask[i] = (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (issue && id_is_load && (id_rd == REG_W'(i)) && (i != ZERO_REG)) begin
                    cnt_q[i] <= CTR_W'(LOAD_LAT);
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - CTR_W'(1);
                end
            end
            if (stall && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances (latency 1, 2 and 7 with a
// 2-bit stall counter) share one stimulus stream and are reset between scenarios.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_use_rn;
    logic       id_use_rm;
    logic [4:0] id_rd;
    logic       id_is_load;
    logic       ex_branch_taken;

    logic        a_stall, a_pc_write, a_ifid_write, a_idex_bubble, a_ifid_flush;
    logic [31:0] a_mask;
    logic [15:0] a_cnt;
    logic        b_stall, b_pc_write, b_ifid_write, b_idex_bubble, b_ifid_flush;
    logic [31:0] b_mask;
    logic [15:0] b_cnt;
    logic        c_stall, c_pc_write, c_ifid_write, c_idex_bubble, c_ifid_flush;
    logic [31:0] c_mask;
    logic [1:0]  c_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.LOAD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .stall(a_stall), .pc_write(a_pc_write),
        .ifid_write(a_ifid_write), .idex_bubble(a_idex_bubble), .ifid_flush(a_ifid_flush),
        .pending_mask(a_mask), .stall_count(a_cnt)
    );

    hazard_scoreboard #(.LOAD_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .stall(b_stall), .pc_write(b_pc_write),
        .ifid_write(b_ifid_write), .idex_bubble(b_idex_bubble), .ifid_flush(b_ifid_flush),
        .pending_mask(b_mask), .stall_count(b_cnt)
    );

    hazard_scoreboard #(.LOAD_LAT(7), .CNT_W(2)) u_lat7 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .stall(c_stall), .pc_write(c_pc_write),
        .ifid_write(c_ifid_write), .idex_bubble(c_idex_bubble), .ifid_flush(c_ifid_flush),
        .pending_mask(c_mask), .stall_count(c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1-2 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rn, input logic urn, input logic [4:0] rm,
                         input logic urm, input logic [4:0] rd, input logic ld, input logic br);
        id_valid = v; id_rn = rn; id_use_rn = urn; id_rm = rm; id_use_rm = urm;
        id_rd = rd; id_is_load = ld; ex_branch_taken = br;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [1:0] sat_exp [5];

    initial begin
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        reset = 1'b0;

        // Reset state
        do_reset();
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_pc_write", 32'(a_pc_write), 32'd1);
        check("rst_ifid_write", 32'(a_ifid_write), 32'd1);
        check("rst_bubble", 32'(a_idex_bubble), 32'd0);
        check("rst_flush", 32'(a_ifid_flush), 32'd0);
        check("rst_mask", a_mask, 32'd0);
        check("rst_count", 32'(a_cnt), 32'd0);

        // LAT1: LDUR X2 ; ADD X3,X2,X4
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        check("l1_load_stall", 32'(a_stall), 32'd0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 1'b0);
        check("l1_dep_stall", 32'(a_stall), 32'd1);
        check("l1_dep_pc_write", 32'(a_pc_write), 32'd0);
        check("l1_dep_ifid_write", 32'(a_ifid_write), 32'd0);
        check("l1_dep_bubble", 32'(a_idex_bubble), 32'd1);
        tick();
        check("l1_issue_stall", 32'(a_stall), 32'd0);
        check("l1_issue_bubble", 32'(a_idex_bubble), 32'd0);
        check("l1_count", 32'(a_cnt), 32'd1);

        // LAT2: LDUR X5 ; ADD X8,X9,X10 ; SUB X6,X5,X1
        do_reset();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        check("l2_mask5_a", 32'(b_mask[5]), 32'd1);
        drive(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd8, 1'b0, 1'b0);
        check("l2_indep_stall", 32'(b_stall), 32'd0);
        tick();
        check("l2_mask5_b", 32'(b_mask[5]), 32'd1);
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0);
        check("l2_dep_stall", 32'(b_stall), 32'd1);
        tick();
        check("l2_mask5_c", 32'(b_mask[5]), 32'd0);
        check("l2_release", 32'(b_stall), 32'd0);
        check("l2_count", 32'(b_cnt), 32'd1);

        // XZR: LDUR X31 ; ADD X1,X31,X31 ; LDUR X1 ; ADD X2,X31,X31
        do_reset();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0);
        tick();
        check("xzr_load_mask", b_mask, 32'd0);
        drive(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd1, 1'b0, 1'b0);
        check("xzr_src_stall", 32'(b_stall), 32'd0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd2, 1'b0, 1'b0);
        check("xzr_read_stall", 32'(b_stall), 32'd0);
        check("xzr_mask31", 32'(b_mask[31]), 32'd0);
        tick();

        // Self-dependent load LDUR X1,[X1]: no stall
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        check("self_load_stall", 32'(b_stall), 32'd0);
        tick();

        // LAT1 branch flush in the hazard cycle
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 1'b1);
        check("br_stall", 32'(a_stall), 32'd0);
        check("br_flush", 32'(a_ifid_flush), 32'd1);
        check("br_bubble", 32'(a_idex_bubble), 32'd1);
        check("br_mask2", 32'(a_mask[2]), 32'd1);
        tick();
        idle();
        check("br_count", 32'(a_cnt), 32'd0);
        check("br_mask_after", a_mask, 32'd0);

        // LAT2 reset mid-countdown
        do_reset();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        check("rc_mask7", 32'(b_mask[7]), 32'd1);
        do_reset();
        check("rc_mask", b_mask, 32'd0);
        drive(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0);
        check("rc_dep_stall", 32'(b_stall), 32'd0);
        tick();
        check("rc_count", 32'(b_cnt), 32'd0);

        // LAT7, CNT_W=2: saturating stall counter
        do_reset();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sat_stall_%0d", i), 32'(c_stall), 32'd1);
            tick();
            check($sformatf("sat_count_%0d", i), 32'(c_cnt), 32'(sat_exp[i]));
        end
        for (int i = 5; i < 7; i++) begin
            check($sformatf("sat_stall_%0d", i), 32'(c_stall), 32'd1);
            tick();
        end
        check("sat_release", 32'(c_stall), 32'd0);
        check("sat_hold", 32'(c_cnt), 32'd3);

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
